// File: rtl/shift_reg_seq_pkg.sv
//------------------------------------------------------------------------------
// shift_reg_seq_pkg : mode codes, FSM encoding and single-step shift function
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package shift_reg_seq_pkg;

  localparam logic [2:0] MODE_HOLD = 3'd0;
  localparam logic [2:0] MODE_LOAD = 3'd1;
  localparam logic [2:0] MODE_SHL  = 3'd2;
  localparam logic [2:0] MODE_SHR  = 3'd3;
  localparam logic [2:0] MODE_ROL  = 3'd4;
  localparam logic [2:0] MODE_ROR  = 3'd5;
  localparam logic [2:0] MODE_ASR  = 3'd6;
  localparam logic [2:0] MODE_CLR  = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // The step function works on a fixed-width container; callers zero-extend.
  localparam int MAX_W = 64;
  localparam int IDX_W = 6;

  typedef struct packed {
    logic [MAX_W-1:0] q;
    logic             out;
  } step_t;

  function automatic logic is_shift_mode(input logic [2:0] mode);
    return (mode == MODE_SHL) || (mode == MODE_SHR) || (mode == MODE_ROL) ||
           (mode == MODE_ROR) || (mode == MODE_ASR);
  endfunction

  function automatic step_t shift_step(input logic [MAX_W-1:0] q,
                                       input logic [IDX_W-1:0] msb,
                                       input logic [2:0]       mode,
                                       input logic             sin);
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] top;
    logic [MAX_W-1:0] nq;
    step_t            r;
    mask  = {MAX_W{1'b1}} >> (IDX_W'(MAX_W-1) - msb);
    top   = {{(MAX_W-1){1'b0}}, 1'b1} << msb;
    nq    = q;
    r.out = 1'b0;
    case (mode)
      MODE_SHL: begin nq = {q[MAX_W-2:0], sin};    r.out = q[msb]; end
      MODE_ROL: begin nq = {q[MAX_W-2:0], q[msb]}; r.out = q[msb]; end
      MODE_SHR: begin nq = (q >> 1) | (sin    ? top : '0); r.out = q[0]; end
      MODE_ROR: begin nq = (q >> 1) | (q[0]   ? top : '0); r.out = q[0]; end
      MODE_ASR: begin nq = (q >> 1) | (q[msb] ? top : '0); r.out = q[0]; end
      default: ;
    endcase
    r.q = nq & mask;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/shift_step_comb.sv
//------------------------------------------------------------------------------
// shift_step_comb : combinational single-bit step, yields next q and out-bit
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_step_comb
  import shift_reg_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q_in,
  input  logic [2:0]       mode,
  input  logic             sin,
  output logic [WIDTH-1:0] q_out,
  output logic             out_bit
);

  localparam logic [IDX_W-1:0] MSB_IDX = IDX_W'(WIDTH-1);

  logic [MAX_W-1:0] q_ext;
  step_t            step;

  always_comb begin
    q_ext            = '0;
    q_ext[WIDTH-1:0] = q_in;
    step             = shift_step(q_ext, MSB_IDX, mode, sin);
  end

  assign q_out   = step.q[WIDTH-1:0];
  assign out_bit = step.out;

  // Bits above WIDTH are always zero after masking.
  if (WIDTH < MAX_W) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^step.q[MAX_W-1:WIDTH];
  end

endmodule

`default_nettype wire

// File: rtl/shift_reg_seq.sv
//------------------------------------------------------------------------------
// shift_reg_seq : sequenced falling-edge shift register with busy/done handshake
// Optional abort input enabled by macro SHIFT_REG_SEQ_ABORT_EN. Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module shift_reg_seq
  import shift_reg_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int AMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [AMT_W-1:0] amt,
  input  logic [WIDTH-1:0] load_d,
  input  logic             sin,
`ifdef SHIFT_REG_SEQ_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [2:0]       mode_q, mode_d;
  logic [AMT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             sout_q, sout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [2:0]       step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_out;
  logic             abort_req;

`ifdef SHIFT_REG_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // The first step happens on the start edge, before mode is latched.
  assign step_mode = (state_q == ST_IDLE) ? mode : mode_q;

  shift_step_comb #(
    .WIDTH(WIDTH)
  ) u_step (
    .q_in   (q_q),
    .mode   (step_mode),
    .sin    (sin),
    .q_out  (step_q),
    .out_bit(step_out)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    rem_d   = rem_q;
    q_d     = q_q;
    sout_d  = sout_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DONE;
          case (mode)
            MODE_LOAD: q_d = load_d;
            MODE_CLR:  q_d = '0;
            default: begin
              if (is_shift_mode(mode) && (amt != '0)) begin
                q_d    = step_q;
                sout_d = step_out;
                mode_d = mode;
                rem_d  = amt - 1'b1;
                busy_d = 1'b1;
                if (amt != AMT_W'(1)) state_d = ST_SHIFT;
              end
            end
          endcase
        end
      end
      ST_SHIFT: begin
        if (abort_req) begin
          busy_d  = 1'b0;
          state_d = ST_DONE;
        end else begin
          q_d    = step_q;
          sout_d = step_out;
          rem_d  = rem_q - 1'b1;
          // busy stays high through the final step cycle; DONE clears it.
          if (rem_q == AMT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_HOLD;
      rem_q   <= '0;
      q_q     <= '0;
      sout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      rem_q   <= rem_d;
      q_q     <= q_d;
      sout_q  <= sout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q    = q_q;
  assign sout = sout_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_seq.sv
//------------------------------------------------------------------------------
// tb_shift_reg_seq : directed and random commands against a closed-form model
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_reg_seq;

  localparam int W     = 8;
  localparam int AMT_W = 4;
  localparam int MASK  = 255;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [2:0]       mode;
  logic [AMT_W-1:0] amt;
  logic [W-1:0]     load_d;
  logic             sin;
`ifdef SHIFT_REG_SEQ_ABORT_EN
  logic             abort;
`endif
  logic [W-1:0]     q;
  logic             sout;
  logic             busy;
  logic             done;

  int n_checks = 0;
  int n_errors = 0;
  int model_q;
  int model_sout;

  always #5 clk = ~clk;

  shift_reg_seq #(
    .WIDTH(W),
    .AMT_W(AMT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .mode  (mode),
    .amt   (amt),
    .load_d(load_d),
    .sin   (sin),
`ifdef SHIFT_REG_SEQ_ABORT_EN
    .abort (abort),
`endif
    .q     (q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Net effect of n single-bit steps, written directly in closed form.
  function automatic void model_apply(input int md, input int n, input int ld, input int s);
    int r;
    int sign;
    int fill;
    r    = n % W;
    sign = (model_q >> (W-1)) & 1;
    fill = s ? MASK : 0;
    case (md)
      1: model_q = ld;
      7: model_q = 0;
      2: if (n > 0) begin
        model_sout = (n <= W) ? ((model_q >> (W-n)) & 1) : s;
        model_q    = (n >= W) ? fill : (((model_q << n) | (s ? ((1 << n) - 1) : 0)) & MASK);
      end
      3: if (n > 0) begin
        model_sout = (n <= W) ? ((model_q >> (n-1)) & 1) : s;
        model_q    = (n >= W) ? fill : ((model_q >> n) | (s ? (((1 << n) - 1) << (W-n)) : 0));
      end
      4: if (n > 0) begin
        model_sout = (model_q >> ((W - r) % W)) & 1;
        model_q    = ((model_q << r) | (model_q >> (W - r))) & MASK;
      end
      5: if (n > 0) begin
        model_sout = (model_q >> ((n-1) % W)) & 1;
        model_q    = ((model_q >> r) | (model_q << (W - r))) & MASK;
      end
      6: if (n > 0) begin
        model_sout = (model_q >> ((n-1 < W-1) ? n-1 : W-1)) & 1;
        model_q    = (n >= W) ? (sign ? MASK : 0)
                   : ((model_q >> n) | (sign ? ((MASK << (W-n)) & MASK) : 0));
      end
      default: ;
    endcase
  endfunction

  // Issue one command, track busy/done timing, then compare final state.
  task automatic run_cmd(input string tag, input int md, input int n, input int ld,
                         input int s, input bit junk);
    int busy_cnt;
    int done_at;
    bit shifting;
    busy_cnt = 0;
    done_at  = 0;
    shifting = (md >= 2) && (md <= 6) && (n > 0);
    mode   = 3'(md);
    amt    = AMT_W'(n);
    load_d = W'(ld);
    sin    = 1'(s);
    start  = 1'b1;
    model_apply(md, n, ld, s);
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      @(posedge clk);
      if (busy) busy_cnt++;
      if (done) done_at = c;
      if (junk && !done) begin
        start  = 1'($urandom_range(0, 1));
        mode   = 3'($urandom);
        amt    = AMT_W'($urandom);
        load_d = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    check_eq({tag, ":done_cycle"}, done_at, shifting ? n + 1 : 2);
    check_eq({tag, ":busy_cycles"}, busy_cnt, shifting ? n : 0);
    check_eq({tag, ":q"}, int'(q), model_q);
    check_eq({tag, ":sout"}, int'(sout), model_sout);
    @(posedge clk);
    check_eq({tag, ":done_after"}, int'(done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int done_seen;
    reset  = 1'b0;
    start  = 1'b1;
    mode   = 3'd1;
    amt    = '0;
    load_d = 8'hFF;
    sin    = 1'b0;
`ifdef SHIFT_REG_SEQ_ABORT_EN
    abort  = 1'b0;
`endif
    repeat (2) @(posedge clk);
    check_eq("reset:q", int'(q), 0);
    check_eq("reset:busy", int'(busy), 0);
    check_eq("reset:done", int'(done), 0);
    check_eq("reset:sout", int'(sout), 0);
    reset      = 1'b1;
    start      = 1'b0;
    model_q    = 0;
    model_sout = 0;

    run_cmd("load_a5", 1, 0, 'hA5, 0, 1'b0);
    run_cmd("load_81", 1, 0, 'h81, 0, 1'b0);
    run_cmd("rol3", 4, 3, 0, 0, 1'b0);
    check_eq("rol3:q_const", int'(q), 'h0C);
    run_cmd("load_90", 1, 0, 'h90, 0, 1'b0);
    run_cmd("asr10", 6, 10, 0, 0, 1'b1);
    check_eq("asr10:q_const", int'(q), 'hFF);
    run_cmd("load_01", 1, 0, 'h01, 0, 1'b0);
    run_cmd("shl0", 2, 0, 0, 1, 1'b0);
    run_cmd("shl2", 2, 2, 0, 1, 1'b0);
    check_eq("shl2:q_const", int'(q), 'h07);
    run_cmd("clr", 7, 0, 0, 0, 1'b0);

    // Reset during an SHR after two steps.
    run_cmd("load_b6", 1, 0, 'hB6, 0, 1'b0);
    mode  = 3'd3;
    amt   = AMT_W'(5);
    sin   = 1'b1;
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    @(posedge clk);
    check_eq("midrst:busy_before", int'(busy), 1);
    reset = 1'b0;
    @(posedge clk);
    reset = 1'b1;
    check_eq("midrst:q", int'(q), 0);
    check_eq("midrst:busy", int'(busy), 0);
    check_eq("midrst:sout", int'(sout), 0);
    done_seen = 0;
    repeat (8) begin
      @(posedge clk);
      if (done) done_seen++;
    end
    check_eq("midrst:no_done", done_seen, 0);
    model_q    = 0;
    model_sout = 0;

`ifdef SHIFT_REG_SEQ_ABORT_EN
    run_cmd("load_b6b", 1, 0, 'hB6, 0, 1'b0);
    mode  = 3'd3;
    amt   = AMT_W'(5);
    sin   = 1'b0;
    start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    @(posedge clk);
    model_apply(3, 2, 0, 0);
    abort = 1'b1;
    @(posedge clk);
    abort = 1'b0;
    check_eq("abort:busy", int'(busy), 0);
    check_eq("abort:done_early", int'(done), 0);
    check_eq("abort:q", int'(q), model_q);
    @(posedge clk);
    check_eq("abort:done", int'(done), 1);
    check_eq("abort:q_hold", int'(q), model_q);
    check_eq("abort:sout", int'(sout), model_sout);
    @(posedge clk);
    check_eq("abort:done_after", int'(done), 0);
`endif

    for (int i = 0; i < 40; i++) begin
      run_cmd($sformatf("rnd%0d", i), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 255)), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
